// File: rtl/mux_pkg.sv
// Shared definitions for the 4-bit mux serializer: FSM encoding, select
// constants and select-stepping helpers.
package mux_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   localparam int                 SEL_W         = 2;
   localparam logic [SEL_W-1:0]   SEL_FIRST_LSB = 2'd0;
   localparam logic [SEL_W-1:0]   SEL_LAST_LSB  = 2'd3;
   localparam logic [SEL_W-1:0]   SEL_ONE       = 2'd1;

   // Select loaded on word acceptance.
   function automatic logic [SEL_W-1:0] sel_first(input logic msb_first);
      logic [SEL_W-1:0] v;
      if (msb_first) v = SEL_LAST_LSB;
      else           v = SEL_FIRST_LSB;
      return v;
   endfunction

   // Select that marks the final bit of a word.
   function automatic logic [SEL_W-1:0] sel_last(input logic msb_first);
      logic [SEL_W-1:0] v;
      if (msb_first) v = SEL_FIRST_LSB;
      else           v = SEL_LAST_LSB;
      return v;
   endfunction

   // Select for the next bit; never called on the terminal select, so no wrap.
   function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] sel,
                                                 input logic             msb_first);
      logic [SEL_W-1:0] v;
      if (msb_first) v = sel - SEL_ONE;
      else           v = sel + SEL_ONE;
      return v;
   endfunction

endpackage

// File: rtl/mux_4to1.sv
// Plain 4:1 bit selector used to pick the current serial bit.
module mux_4to1 (
   input  logic [3:0] a,
   input  logic [1:0] sel,
   output logic       y
);

   // Route the selected input bit to the output.
   always_comb begin
      y = 1'b0;
      case (sel)
         2'd0:    y = a[0];
         2'd1:    y = a[1];
         2'd2:    y = a[2];
         2'd3:    y = a[3];
         default: y = 1'b0;
      endcase
   end

endmodule

// File: rtl/mux_serializer.sv
// Serializes 4-bit words onto a single-bit valid/ready stream. The current
// bit is picked from the captured word by a 4:1 mux driven by sel, so the
// serial output depends on registers only. A new word may be loaded on the
// same edge that the last bit is taken, giving gap-free back-to-back words.
module mux_serializer
   import mux_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b0
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_last,
   output logic [SEL_W-1:0] sel
);

   localparam logic [SEL_W-1:0] C_SEL_FIRST = sel_first(MSB_FIRST);
   localparam logic [SEL_W-1:0] C_SEL_LAST  = sel_last(MSB_FIRST);

   state_e           r_state;
   logic [3:0]       r_word;
   logic [SEL_W-1:0] r_sel;

   state_e           w_state_nxt;
   logic [3:0]       w_word_nxt;
   logic [SEL_W-1:0] w_sel_nxt;
   logic             w_shift;
   logic             w_last;
   logic             w_take;
   logic             w_accept;

   assign w_shift  = (r_state == ST_SHIFT);
   assign w_last   = w_shift && (r_sel == C_SEL_LAST);
   assign w_take   = w_shift && ser_ready;
   assign w_accept = in_valid && in_ready;

   assign ser_valid = w_shift;
   assign ser_last  = w_last;
   assign sel       = r_sel;
   assign in_ready  = (r_state == ST_IDLE) || (w_take && w_last);

   // Bit selector: the serial bit is word_reg[sel].
   mux_4to1 u_mux (
      .a   (r_word),
      .sel (r_sel),
      .y   (ser_out)
   );

   // FSM, captured word and select registers; reset discards any partial word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_word  <= 4'd0;
         r_sel   <= SEL_FIRST_LSB;
      end else begin
         r_state <= w_state_nxt;
         r_word  <= w_word_nxt;
         r_sel   <= w_sel_nxt;
      end
   end

   // Next-state logic: accept in IDLE, step on each taken bit, reload or
   // return to IDLE when the last bit is taken, hold while stalled.
   always_comb begin
      w_state_nxt = r_state;
      w_word_nxt  = r_word;
      w_sel_nxt   = r_sel;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_SHIFT;
               w_word_nxt  = in_data;
               w_sel_nxt   = C_SEL_FIRST;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (w_take && w_last) begin
               if (in_valid) begin
                  w_state_nxt = ST_SHIFT;
                  w_word_nxt  = in_data;
                  w_sel_nxt   = C_SEL_FIRST;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (w_take) begin
               w_sel_nxt = sel_step(r_sel, MSB_FIRST);
            end else begin
               w_state_nxt = ST_SHIFT;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mux_serializer.sv
// Bench for mux_serializer: an LSB-first and an MSB-first instance share one
// stimulus stream. A word-level model (current word, index of the bit being
// offered) predicts every output each cycle, a scoreboard reassembles the
// emitted bits into words, and directed scenarios pin literal expectations.
module tb_mux_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] in_data;
   logic       in_valid;
   logic       ser_ready;

   logic       ir0, so0, sv0, sl0;
   logic [1:0] sel0;
   logic       ir1, so1, sv1, sl1;
   logic [1:0] sel1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_serializer #(.MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(ir0), .ser_out(so0), .ser_valid(sv0), .ser_ready(ser_ready),
      .ser_last(sl0), .sel(sel0)
   );

   mux_serializer #(.MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(ir1), .ser_out(so1), .ser_valid(sv1), .ser_ready(ser_ready),
      .ser_last(sl1), .sel(sel1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model + scoreboard ----------------
   bit         m_active = 1'b0;
   logic [3:0] m_word   = 4'd0;
   int         m_k      = 0;      // how many bits of m_word already sent
   logic [3:0] acc_q[$];
   logic [3:0] asm0, asm1;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_valid_lsb", sv0, 1'b0);
         chk("rst_valid_msb", sv1, 1'b0);
         chk("rst_ready_lsb", ir0, 1'b1);
         chk("rst_ready_msb", ir1, 1'b1);
         chk("rst_last_lsb",  sl0, 1'b0);
         chk("rst_last_msb",  sl1, 1'b0);
         chk("rst_out_lsb",   so0, 1'b0);
         chk("rst_out_msb",   so1, 1'b0);
         chk("rst_sel_lsb",   sel0, 2'd0);
         chk("rst_sel_msb",   sel1, 2'd0);
         m_active = 1'b0;
         m_k      = 0;
         acc_q.delete();
      end else begin
         chk("valid_lsb", sv0, m_active);
         chk("valid_msb", sv1, m_active);
         chk("ready_lsb", ir0, !m_active || (ser_ready && m_k == 3));
         chk("ready_msb", ir1, !m_active || (ser_ready && m_k == 3));
         chk("last_lsb",  sl0, m_active && m_k == 3);
         chk("last_msb",  sl1, m_active && m_k == 3);
         if (m_active) begin
            chk("out_lsb", so0, m_word[m_k]);
            chk("out_msb", so1, m_word[3 - m_k]);
            chk("sel_lsb", sel0, m_k);
            chk("sel_msb", sel1, 3 - m_k);
            if (ser_ready) begin
               asm0[m_k]     = so0;
               asm1[3 - m_k] = so1;
               if (m_k == 3) begin
                  if (acc_q.size() > 0) begin
                     chk("reasm_lsb", asm0, acc_q[0]);
                     chk("reasm_msb", asm1, acc_q[0]);
                     void'(acc_q.pop_front());
                  end else begin
                     chk("reasm_queue_nonempty", 32'd0, 32'd1);
                  end
               end
            end
         end
         // advance the model to what holds after the coming rising edge
         if (m_active && ser_ready && m_k == 3) begin
            if (in_valid) begin
               m_word = in_data; m_k = 0; acc_q.push_back(in_data);
            end else begin
               m_active = 1'b0;
            end
         end else if (m_active && ser_ready) begin
            m_k++;
         end else if (!m_active && in_valid) begin
            m_word = in_data; m_k = 0; m_active = 1'b1; acc_q.push_back(in_data);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_random(input logic [3:0] w);
      bit done = 1'b0;
      in_data  = w;
      in_valid = 1'b1;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         done = ir0;
         tick();
         ser_ready = ($urandom_range(0, 3) != 0);
      end
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
      in_valid = ($urandom_range(0, 1) == 1);
   endtask

   int exp_lsb[4] = '{1, 1, 0, 1};
   int exp_msb[4] = '{1, 0, 1, 1};
   int exp_sm[4]  = '{3, 2, 1, 0};
   int exp_b2b[8] = '{0, 1, 0, 1, 1, 0, 1, 0};

   initial begin
      rst = 1'b1; in_data = 4'd0; in_valid = 1'b0; ser_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // basic LSB-first / MSB-first of 4'b1011
      in_data = 4'b1011; in_valid = 1'b1; ser_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("d1_out_lsb", so0, exp_lsb[i]);
         chk("d1_out_msb", so1, exp_msb[i]);
         chk("d1_sel_msb", sel1, exp_sm[i]);
         chk("d1_last_lsb", sl0, i == 3);
         tick();
      end
      @(negedge clk);
      chk("d1_ready_after", ir0, 1'b1);
      chk("d1_valid_after", sv0, 1'b0);
      tick();

      // backpressure on bit 2 of 4'b0110
      in_data = 4'b0110; in_valid = 1'b1; ser_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      ser_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("d2_hold_out", so0, 1'b1);
         chk("d2_hold_sel", sel0, 2'd2);
         chk("d2_hold_last", sl0, 1'b0);
         tick();
      end
      ser_ready = 1'b1;
      @(negedge clk);
      chk("d2_bit2_out", so0, 1'b1);
      tick();
      @(negedge clk);
      chk("d2_bit3_out", so0, 1'b0);
      chk("d2_bit3_sel", sel0, 2'd3);
      chk("d2_bit3_last", sl0, 1'b1);
      tick();
      tick();

      // back-to-back 4'hA then 4'h5
      in_data = 4'hA; in_valid = 1'b1; ser_ready = 1'b1;
      tick();
      in_data = 4'h5;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("d3_valid", sv0, 1'b1);
         chk("d3_out", so0, exp_b2b[i]);
         chk("d3_ready", ir0, (i == 3) || (i == 7));
         tick();
         if (i == 3) in_valid = 1'b0;
      end
      @(negedge clk);
      chk("d3_idle", sv0, 1'b0);
      tick();

      // reset mid-word of 4'hF, then 4'h0 at the first edge after release
      in_data = 4'hF; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      chk("d4_async_valid_lsb", sv0, 1'b0);
      chk("d4_async_valid_msb", sv1, 1'b0);
      chk("d4_async_ready", ir0, 1'b1);
      in_data = 4'h0; in_valid = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("d4_valid", sv0, 1'b1);
         chk("d4_out", so0, 1'b0);
         tick();
      end
      tick();

      // all 16 words, both orders, random ser_ready and in_valid gaps
      for (int r = 0; r < 3; r++) begin
         for (int w = 0; w < 16; w++) begin
            send_random(w[3:0]);
         end
      end
      in_valid  = 1'b0;
      ser_ready = 1'b1;
      repeat (12) tick();
      chk("drain_queue_empty", acc_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
